// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes and channel state types
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// rtl/axi_lite_slave_regs_if.sv - AXI4-Lite AW/W/B/AR/R channel bundle
interface axi_lite_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    RVALID;
  logic                    RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// rtl/axi_lite_addr_decode.sv - byte address to register index and range check
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  localparam int                   IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  in_range
);

  logic [ADDR_WIDTH-1:0] offset;

  // The subtraction wraps for addresses below the base, so that case is checked separately.
  assign offset   = addr - BASE_ADDR;
  assign index    = offset[IDX_W+1:2];
  assign in_range = (addr >= BASE_ADDR) && (offset < ADDR_WIDTH'(NUM_REGS * 4));

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite slave register bank with byte strobes
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  axi_lite_slave_regs_if.slave           bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  ready_en;
  logic                  aw_captured;
  logic                  w_captured;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  do_write;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_index;
  logic [IDX_W-1:0]      rd_index;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  unused_prot;

  assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

  // Readies stay low through reset and for the edge that releases it.
  assign bus.AWREADY = ready_en && (wr_state == WR_IDLE) && !aw_captured;
  assign bus.WREADY  = ready_en && (wr_state == WR_IDLE) && !w_captured;
  assign bus.ARREADY = ready_en && (rd_state == RD_IDLE);

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  assign wr_addr  = aw_captured ? aw_addr_q : bus.AWADDR;
  assign wr_data  = w_captured ? w_data_q : bus.WDATA;
  assign wr_strb  = w_captured ? w_strb_q : bus.WSTRB;
  assign do_write = (aw_captured || aw_hs) && (w_captured || w_hs);

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wr_decode (
    .addr     (wr_addr),
    .index    (wr_index),
    .in_range (wr_in_range)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rd_decode (
    .addr     (bus.ARADDR),
    .index    (rd_index),
    .in_range (rd_in_range)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state    <= WR_IDLE;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_captured <= 1'b1;
            aw_addr_q   <= bus.AWADDR;
          end
          if (w_hs) begin
            w_captured <= 1'b1;
            w_data_q   <= bus.WDATA;
            w_strb_q   <= bus.WSTRB;
          end
          // Completion wins over a same-cycle capture so both flags end up clear.
          if (do_write) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            bus.BVALID  <= 1'b1;
            bus.BRESP   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            wr_state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.BREADY) begin
            bus.BVALID <= 1'b0;
            wr_state   <= WR_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (do_write && wr_in_range) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wr_strb[k]) begin
          regs[wr_index][k*8 +: 8] <= wr_data[k*8 +: 8];
        end
      end
    end
  end

  // RDATA samples the register array before any same-edge write lands.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state   <= RD_IDLE;
      bus.RVALID <= 1'b0;
      bus.RDATA  <= '0;
      bus.RRESP  <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            bus.RVALID <= 1'b1;
            bus.RDATA  <= rd_in_range ? regs[rd_index] : '0;
            bus.RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rd_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.RREADY) begin
            bus.RVALID <= 1'b0;
            rd_state   <= RD_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - self-checking bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;

  localparam int          NR = 16;
  localparam logic [31:0] MB = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          idx;
    logic [31:0] word;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*32-1:0] regs_out;
  logic [31:0]      model [NR];
  int               n_vec = 0;
  int               n_miss = 0;

  axi_lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_slave_regs #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (NR),
    .BASE_ADDR  (MB)
  ) dut (
    .ACLK     (clk),
    .ARESETn  (rst_n),
    .bus      (bus),
    .regs_out (regs_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic check_regs(input string name);
    int bad = -1;
    for (int i = 0; i < NR; i++) begin
      if (bad < 0 && regs_out[i*32 +: 32] !== model[i]) bad = i;
    end
    n_vec++;
    if (bad >= 0) begin
      n_miss++;
      $display("FAIL %s: word %0d got %h expected %h", name, bad, regs_out[bad*32 +: 32], model[bad]);
    end
  endtask

  function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    longint off = longint'(a) - longint'(MB);
    if (off < 0 || off >= NR * 4) return 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) model[off/4][k*8 +: 8] = d[k*8 +: 8];
    end
    return 2'b00;
  endfunction

  function automatic logic [33:0] m_read(input logic [31:0] a);
    longint off = longint'(a) - longint'(MB);
    if (off < 0 || off >= NR * 4) return {2'b10, 32'h0};
    return {2'b00, model[off/4]};
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0;
    bit w_done = 0;
    bit a_rdy;
    bit w_rdy;
    int cyc = 0;
    @(negedge clk);
    bus.AWVALID = 1'b1; bus.AWADDR = addr;
    bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb;
    bus.BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      a_rdy = bus.AWREADY;
      w_rdy = bus.WREADY;
      @(posedge clk); #1; cyc++;
      if (a_rdy && !aw_done) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_rdy && !w_done) begin w_done = 1; bus.WVALID = 1'b0; end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    if (!(aw_done && w_done)) fail("write handshake");
    lat = 0;
    while (!bus.BVALID && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!bus.BVALID) fail("bvalid wait");
    resp = bus.BRESP;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0;
    bit r;
    int cyc = 0;
    @(negedge clk);
    bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.RREADY = 1'b1;
    while (!done && cyc < 20) begin
      r = bus.ARREADY;
      @(posedge clk); #1; cyc++;
      if (r) begin done = 1; bus.ARVALID = 1'b0; end
    end
    bus.ARVALID = 1'b0;
    if (!done) fail("read handshake");
    cyc = 0;
    while (!bus.RVALID && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!bus.RVALID) fail("rvalid wait");
    data = bus.RDATA;
    resp = bus.RRESP;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
  endtask

  initial begin
    vec_t        vt [8];
    logic [1:0]  resp;
    logic [1:0]  exp_resp;
    logic [31:0] rd;
    logic [31:0] old;
    logic [33:0] mr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;

    vt[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 2,  32'hDEADBEEF};
    vt[1] = '{32'h08, 32'h000000AA, 4'h1, 2'b00, 2,  32'hDEADBEAA};
    vt[2] = '{32'h40, 32'h11111111, 4'hF, 2'b10, 2,  32'hDEADBEAA};
    vt[3] = '{32'h3C, 32'hA5A5A5A5, 4'hC, 2'b00, 15, 32'hA5A50000};
    vt[4] = '{32'h01, 32'hCAFEF00D, 4'hF, 2'b00, 0,  32'hCAFEF00D};
    vt[5] = '{32'h04, 32'hFFFFFFFF, 4'h0, 2'b00, 1,  32'h00000000};
    vt[6] = '{32'hFFFFFFFC, 32'h12345678, 4'hF, 2'b10, 0, 32'hCAFEF00D};
    vt[7] = '{32'h3E, 32'h0000BB00, 4'h2, 2'b00, 15, 32'hA5A5BB00};

    bus.AWVALID = 0; bus.AWADDR = 0; bus.AWPROT = 0;
    bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = 0; bus.ARPROT = 0; bus.RREADY = 0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset awready", 32'(bus.AWREADY), 0);
    check("reset wready", 32'(bus.WREADY), 0);
    check("reset arready", 32'(bus.ARREADY), 0);
    check("reset bvalid", 32'(bus.BVALID), 0);
    check("reset rvalid", 32'(bus.RVALID), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arready before first edge", 32'(bus.ARREADY), 0);
    @(posedge clk); #1;
    check("awready after release", 32'(bus.AWREADY), 1);
    check("wready after release", 32'(bus.WREADY), 1);
    check("arready after release", 32'(bus.ARREADY), 1);
    check_regs("reset regs");

    for (int i = 0; i < 8; i++) begin
      axi_write(vt[i].addr, vt[i].data, vt[i].strb, resp, lat);
      void'(m_write(vt[i].addr, vt[i].data, vt[i].strb));
      check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vt[i].resp));
      check($sformatf("vec%0d b latency", i), lat, 0);
      check($sformatf("vec%0d word", i), regs_out[vt[i].idx*32 +: 32], vt[i].word);
      axi_read(vt[i].addr, rd, resp);
      check($sformatf("vec%0d rresp", i), 32'(resp), 32'(vt[i].resp));
      check($sformatf("vec%0d rdata", i), rd, (vt[i].resp == 2'b00) ? vt[i].word : 32'h0);
      check_regs($sformatf("vec%0d regs", i));
    end

    // W leads AW by two cycles
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, resp, lat);
    void'(m_write(32'h08, 32'hDEADBEEF, 4'hF));
    @(negedge clk);
    bus.WVALID = 1'b1; bus.WDATA = 32'h000000AA; bus.WSTRB = 4'h1; bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("w-first awready", 32'(bus.AWREADY), 1);
      check("w-first wready", 32'(bus.WREADY), 0);
      check("w-first bvalid", 32'(bus.BVALID), 0);
      if (c == 0) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h08;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    void'(m_write(32'h08, 32'h000000AA, 4'h1));
    check("w-first bvalid after aw", 32'(bus.BVALID), 1);
    check("w-first bresp", 32'(bus.BRESP), 0);
    check("w-first word2", regs_out[2*32 +: 32], 32'hDEADBEAA);
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    check("w-first bvalid cleared", 32'(bus.BVALID), 0);

    // B back-pressure with a second write waiting
    @(negedge clk);
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h0C;
    bus.WVALID = 1'b1; bus.WDATA = 32'h11223344; bus.WSTRB = 4'hF; bus.BREADY = 1'b0;
    @(posedge clk); #1;
    void'(m_write(32'h0C, 32'h11223344, 4'hF));
    check("bp bvalid", 32'(bus.BVALID), 1);
    bus.AWADDR = 32'h10; bus.WDATA = 32'h55667788;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp bvalid held", 32'(bus.BVALID), 1);
      check("bp bresp held", 32'(bus.BRESP), 0);
      check("bp awready", 32'(bus.AWREADY), 0);
      check("bp wready", 32'(bus.WREADY), 0);
    end
    check_regs("bp second write blocked");
    @(negedge clk);
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    check("bp b handshake", 32'(bus.BVALID), 0);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    void'(m_write(32'h10, 32'h55667788, 4'hF));
    check("bp second bvalid", 32'(bus.BVALID), 1);
    check_regs("bp second write");
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    check("bp second bvalid cleared", 32'(bus.BVALID), 0);

    // read and write of the same register on one edge
    old = model[2];
    @(negedge clk);
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h08;
    bus.WVALID = 1'b1; bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF; bus.BREADY = 1'b1;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h08; bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    void'(m_write(32'h08, 32'h12345678, 4'hF));
    check("collide rvalid", 32'(bus.RVALID), 1);
    check("collide rdata old", bus.RDATA, old);
    check("collide bvalid", 32'(bus.BVALID), 1);
    @(posedge clk); #1;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    axi_read(32'h08, rd, resp);
    check("collide reread", rd, 32'h12345678);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, NR * 4 + 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        s = 4'($urandom_range(0, 15));
        exp_resp = m_write(a, d, s);
        axi_write(a, d, s, resp, lat);
        check($sformatf("rand wr %h bresp", a), 32'(resp), 32'(exp_resp));
        check_regs($sformatf("rand wr %h regs", a));
      end else begin
        mr = m_read(a);
        axi_read(a, rd, resp);
        check($sformatf("rand rd %h rresp", a), 32'(resp), 32'(mr[33:32]));
        check($sformatf("rand rd %h rdata", a), rd, mr[31:0]);
      end
    end

    // asynchronous reset while a read response is stalled
    @(negedge clk);
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h08; bus.RREADY = 1'b0;
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    check("pre-reset rvalid", 32'(bus.RVALID), 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    check("async reset rvalid", 32'(bus.RVALID), 0);
    check("async reset arready", 32'(bus.ARREADY), 0);
    check_regs("async reset regs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-release arready before edge", 32'(bus.ARREADY), 0);
    @(posedge clk); #1;
    check("post-release arready", 32'(bus.ARREADY), 1);
    check("post-release rvalid", 32'(bus.RVALID), 0);
    check("post-release bvalid", 32'(bus.BVALID), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
